conv_sequencer: RTL
===================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter MAX_DIM, default 16, giving the maximum input height/width in pixels.
REQ-002 SHALL have parameter ADDR_W, default 8, giving the input/output buffer address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle job launch.
REQ-006 SHALL have port in_h, in_w  input  5 each  input feature-map height and width.
REQ-007 SHALL have port stride  input  2  window step; value 0 is treated as 1.
REQ-008 SHALL have port padding  input  2  zero border width.
REQ-009 SHALL have port busy, done  output  1 each  job active, and one-cycle completion pulse.
REQ-010 SHALL have port rd_en, rd_addr  output  1/ADDR_W  input-buffer read; rd_data (input, 4 bits) is valid one cycle after rd_en.
REQ-011 SHALL have port conv_start, conv_in  output  1/36  launch the convolution datapath with a packed 3x3 window, tap k in bits [4k+3:4k].
REQ-012 SHALL have port conv_result  input  32  datapath sum, valid the cycle after conv_start.
REQ-013 SHALL have port wr_en, wr_addr, wr_data  output  1/ADDR_W/32  output-buffer write.

Function
REQ-014 SHALL sample in_h, in_w, stride and padding on an accepted start and hold them until done; input changes while busy SHALL have no effect.
REQ-015 SHALL compute output dimensions as out = (in + 2*padding - 3)/stride + 1 (integer floor), separately for height and width.
REQ-016 SHALL, if in_h+2p < 3 or in_w+2p < 3, go IDLE->DONE with no reads and no writes.
REQ-017 SHALL use states IDLE, FETCH, DRAIN, ISSUE, WRITE, DONE; transitions are IDLE->FETCH on start, FETCH->DRAIN after tap 8, DRAIN->ISSUE, ISSUE->WRITE, WRITE->FETCH (more outputs) or DONE (last output), DONE->IDLE.
REQ-018 SHALL issue, in FETCH, tap k (k=0..8, row-major, dy=k/3, dx=k%3) for one cycle per tap at input coordinate (r*stride+dy-p, c*stride+dx-p).
REQ-019 SHALL, for a tap coordinate outside the input, hold rd_en low and write zero into that nibble of the window.
REQ-020 SHALL set rd_addr = row*in_w + col for in-bounds taps and capture rd_data into the window nibble one cycle later (tap 8 is captured in DRAIN).
REQ-021 SHALL assert conv_start for exactly one cycle in ISSUE, with conv_in holding the complete window.
REQ-022 SHALL, in WRITE, assert wr_en for one cycle with wr_data = conv_result and wr_addr = r*out_w + c; each output takes exactly 12 cycles.
REQ-023 SHALL visit outputs in row-major order, with c wrapping to 0 and r incrementing at out_w-1.
REQ-024 SHALL hold busy high from the cycle after an accepted start through DONE, and pulse done for one cycle in DONE.
REQ-025 SHALL ignore start unless in IDLE; a start coinciding with DONE is dropped.
REQ-026 SHALL keep rd_en, conv_start and wr_en low in all states other than those specified.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-job, immediately enter IDLE and drive busy, done, rd_en, conv_start and wr_en to 0, all addresses to 0, conv_in to 0 and wr_data to 0; no partial write SHALL follow the release of reset.

Configuration
REQ-028 SHALL, with CONV_SEQ_PERF_EN defined, add output perf_cycles (32 bits), which counts busy cycles, clears on an accepted start, saturates at all-ones, and resets to 0.
REQ-029 SHALL, without CONV_SEQ_PERF_EN, have neither the port nor the counter, with all other behaviour identical.

Structure
REQ-030 SHALL place the state encoding, the tap dy/dx constants, the window width (36) and the nibble width (4) in shared package conv_pkg.
REQ-031 SHALL implement coordinate, bounds and address generation in sub-module conv_addr_gen; sequencing SHALL stay in conv_sequencer.

Verification
REQ-032 SHALL verify 3x3 input, stride 1, pad 0: 9 reads (addresses 0..8), 1 write to wr_addr 0, done at cycle 13 after start.
REQ-033 SHALL verify 4x4 input, stride 1, pad 1: 16 writes; for output (0,0), taps 0,1,2,3,6 are zero with no read issued.
REQ-034 SHALL verify 5x5 input, stride 2, pad 0: out 2x2, write addresses 0,1,2,3, and the first window of output (0,1) reads address 2.
REQ-035 SHALL verify 2x2 input, pad 0: done pulse with zero reads and zero writes.
REQ-036 SHALL verify rst_n dropped during the third output's FETCH: all outputs 0 next cycle, then a fresh start completes correctly.
REQ-037 SHALL verify start held high through a whole job: only one job runs, and with CONV_SEQ_PERF_EN perf_cycles equals 12*outputs+1.

Source files
------------

// File: rtl/conv_pkg.sv
// Package shared by the 3x3 convolution sequencer files.
// Holds the FSM state encoding, the tap row/column offsets, the window and
// nibble widths, and helpers that derive output dimensions from a job config.
package conv_pkg;

    localparam int WIN_W    = 36;   // packed 3x3 window, 9 nibbles
    localparam int NIB_W    = 4;    // one input pixel
    localparam int NUM_TAPS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_ISSUE,
        ST_WRITE,
        ST_DONE
    } conv_state_e;

    // Tap k lives at (dy, dx) = (k/3, k%3); two bits per tap, tap 0 in the LSBs.
    localparam logic [17:0] TAP_DY_TBL = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    localparam logic [17:0] TAP_DX_TBL = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] tap_dy(input logic [3:0] k);
        return TAP_DY_TBL[2*k +: 2];
    endfunction

    function automatic logic [1:0] tap_dx(input logic [3:0] k);
        return TAP_DX_TBL[2*k +: 2];
    endfunction

    // True when a padded dimension is wide enough to hold one 3-tap window.
    function automatic logic dim_fits(input logic [4:0] dim, input logic [1:0] pad);
        logic [6:0] span;
        span = {2'b00, dim} + {4'b0000, pad, 1'b0};
        return span >= 7'd3;
    endfunction

    // (dim + 2*pad - 3) / stride + 1; stride must already be non-zero.
    function automatic logic [5:0] out_dim(input logic [4:0] dim, input logic [1:0] pad,
                                           input logic [1:0] stride);
        logic [6:0] span;
        span = {2'b00, dim} + {4'b0000, pad, 1'b0};
        if (span < 7'd3)
            return 6'd0;
        return 6'((span - 7'd3) / {5'b00000, stride}) + 6'd1;
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings.
// master (sequencer): drives the input-buffer read, the datapath launch with
// its window, and the output-buffer write; receives rd_data and conv_result.
// slave (buffers/datapath): the mirror image.
interface conv_sequencer_if import conv_pkg::*; #(
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [NIB_W-1:0]  rd_data;
    logic              conv_start;
    logic [WIN_W-1:0]  conv_in;
    logic [31:0]       conv_result;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output rd_en, rd_addr, conv_start, conv_in, wr_en, wr_addr, wr_data,
        input  rd_data, conv_result
    );

    modport slave (
        input  rd_en, rd_addr, conv_start, conv_in, wr_en, wr_addr, wr_data,
        output rd_data, conv_result
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Coordinate, bounds and address generation for the sequencer.
// Inputs: held job config (in_h, in_w, effective stride, pad), current output
// position (r, c) and tap index.
// Outputs: output dimensions, whether the tap falls inside the input, the
// linear input address of the tap and the linear output address of (r, c).
module conv_addr_gen import conv_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic [4:0]        in_h,
    input  logic [4:0]        in_w,
    input  logic [1:0]        stride,
    input  logic [1:0]        pad,
    input  logic [CNT_W-1:0]  r,
    input  logic [CNT_W-1:0]  c,
    input  logic [3:0]        tap,
    output logic [5:0]        out_h,
    output logic [5:0]        out_w,
    output logic              in_bounds,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);
    // row_p/col_p are the padded-frame coordinates (always >= 0); subtracting
    // pad afterwards keeps everything unsigned, and the >= pad test catches
    // the top/left border.
    logic [9:0] row_p, col_p, row, col;

    always_comb begin
        out_h     = out_dim(in_h, pad, stride);
        out_w     = out_dim(in_w, pad, stride);
        row_p     = 10'(r) * 10'(stride) + 10'(tap_dy(tap));
        col_p     = 10'(c) * 10'(stride) + 10'(tap_dx(tap));
        row       = row_p - 10'(pad);
        col       = col_p - 10'(pad);
        in_bounds = (row_p >= 10'(pad)) && (row < 10'(in_h)) &&
                    (col_p >= 10'(pad)) && (col < 10'(in_w));
        rd_addr   = ADDR_W'(row) * ADDR_W'(in_w) + ADDR_W'(col);
        wr_addr   = ADDR_W'(r) * ADDR_W'(out_w) + ADDR_W'(c);
    end
endmodule

// File: rtl/conv_sequencer.sv
// 3x3 convolution sequencer. For every output pixel, in row-major order, it
// fetches the nine window taps (zero outside the input), launches the
// convolution datapath with the packed window and writes the returned sum.
// Each output takes 12 cycles: 9 FETCH, DRAIN, ISSUE, WRITE.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle job launch, honoured only when idle
//   in_h, in_w            input height/width, sampled at start
//   stride, padding       window step (0 acts as 1) and zero border
//   busy, done            job active / one-cycle completion pulse
//   bus (master)          buffer read, datapath launch, buffer write
//   perf_cycles           busy-cycle counter, only with CONV_SEQ_PERF_EN
// Optional feature: define CONV_SEQ_PERF_EN to add perf_cycles.
module conv_sequencer import conv_pkg::*; #(
    parameter int MAX_DIM = 16,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        in_h,
    input  logic [4:0]        in_w,
    input  logic [1:0]        stride,
    input  logic [1:0]        padding,
    output logic              busy,
    output logic              done,
    conv_sequencer_if.master  bus
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);
    // Largest output dimension is MAX_DIM + 2*3 - 3 + 1.
    localparam int CNT_W = $clog2(MAX_DIM + 5);

    conv_state_e       state_q, state_d;
    logic [CNT_W-1:0]  r_q, r_d, c_q, c_d;
    logic [3:0]        tap_q, tap_d;
    logic [WIN_W-1:0]  window_q, window_d;
    logic              cap_vld_q, cap_vld_d;   // a read is returning this cycle
    logic [3:0]        cap_tap_q, cap_tap_d;   // nibble that read lands in
    logic [4:0]        h_q, h_d, w_q, w_d;
    logic [1:0]        s_q, s_d, p_q, p_d;

    logic              rd_en, conv_start, wr_en;
    logic [5:0]        out_h, out_w;
    logic              in_bounds;
    logic [ADDR_W-1:0] ag_rd_addr, ag_wr_addr;
    logic              last_col, last_row;

    conv_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr_gen (
        .in_h      (h_q),
        .in_w      (w_q),
        .stride    (s_q),
        .pad       (p_q),
        .r         (r_q),
        .c         (c_q),
        .tap       (tap_q),
        .out_h     (out_h),
        .out_w     (out_w),
        .in_bounds (in_bounds),
        .rd_addr   (ag_rd_addr),
        .wr_addr   (ag_wr_addr)
    );

    assign last_col = (c_q == CNT_W'(out_w - 6'd1));
    assign last_row = (r_q == CNT_W'(out_h - 6'd1));

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        tap_d      = tap_q;
        window_d   = window_q;
        cap_vld_d  = 1'b0;
        cap_tap_d  = tap_q;
        h_d        = h_q;
        w_d        = w_q;
        s_d        = s_q;
        p_d        = p_q;
        rd_en      = 1'b0;
        conv_start = 1'b0;
        wr_en      = 1'b0;

        // Read data issued last cycle arrives now; tap 8 lands during DRAIN.
        if (cap_vld_q)
            window_d[cap_tap_q*NIB_W +: NIB_W] = bus.rd_data;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    h_d   = in_h;
                    w_d   = in_w;
                    s_d   = (stride == 2'd0) ? 2'd1 : stride;
                    p_d   = padding;
                    r_d   = '0;
                    c_d   = '0;
                    tap_d = '0;
                    state_d = (dim_fits(in_h, padding) && dim_fits(in_w, padding)) ?
                              ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (in_bounds) begin
                    rd_en     = 1'b1;
                    cap_vld_d = 1'b1;
                end else begin
                    window_d[tap_q*NIB_W +: NIB_W] = '0;
                end
                if (tap_q == 4'(NUM_TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            ST_DRAIN: state_d = ST_ISSUE;
            ST_ISSUE: begin
                conv_start = 1'b1;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (last_col) begin
                    c_d = '0;
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = r_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    c_d     = c_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            tap_q     <= '0;
            window_q  <= '0;
            cap_vld_q <= 1'b0;
            cap_tap_q <= '0;
            h_q       <= '0;
            w_q       <= '0;
            s_q       <= 2'd1;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            tap_q     <= tap_d;
            window_q  <= window_d;
            cap_vld_q <= cap_vld_d;
            cap_tap_q <= cap_tap_d;
            h_q       <= h_d;
            w_q       <= w_d;
            s_q       <= s_d;
            p_q       <= p_d;
        end
    end

    // Addresses and write data are forced to zero whenever their strobe is
    // low, so the bus is all-zero in reset and between accesses.
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = rd_en ? ag_rd_addr : '0;
    assign bus.conv_start = conv_start;
    assign bus.conv_in    = window_q;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_en ? ag_wr_addr : '0;
    assign bus.wr_data    = wr_en ? bus.conv_result : '0;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE && start)
            perf_d = '0;
        else if (busy && perf_q != '1)
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_q <= '0;
        else
            perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule
